// File: rtl/uio_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uio_bus_arbiter_pkg
// Purpose : Shared types and constants for the uio pin-bank arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package uio_bus_arbiter_pkg;

  localparam int UIO_W = 8;
  localparam logic [UIO_W-1:0] OE_DRIVE = 8'hFF;
  localparam logic [UIO_W-1:0] OE_FLOAT = 8'h00;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_TURN = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/uio_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : uio_bus_arbiter_if
// Purpose : Requester-side bus and uio pin bundle seen by the arbiter.
// Revision: 1.0 - initial release
// ============================================================================
interface uio_bus_arbiter_if #(
  parameter int NREQ = 4
);
  import uio_bus_arbiter_pkg::*;

  logic                    ena;
  logic [NREQ-1:0]         req;
  logic [NREQ-1:0]         wr;
  logic [UIO_W*NREQ-1:0]   wdata;
  logic [NREQ-1:0]         done;
  logic [NREQ-1:0]         gnt;
  logic                    busy;
  logic [UIO_W-1:0]        rdata;
  logic                    rvalid;
  logic [UIO_W-1:0]        uio_in;
  logic [UIO_W-1:0]        uio_out;
  logic [UIO_W-1:0]        uio_oe;

  modport master (
    output ena, req, wr, wdata, done, uio_in,
    input  gnt, busy, rdata, rvalid, uio_out, uio_oe
  );

  modport slave (
    input  ena, req, wr, wdata, done, uio_in,
    output gnt, busy, rdata, rvalid, uio_out, uio_oe
  );

endinterface
`default_nettype wire

// File: rtl/uio_bus_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : uio_bus_arbiter_rr_pick
// Purpose : Combinational round-robin pick: first set req at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
module uio_bus_arbiter_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  wire logic [NREQ-1:0]  req,
  input  wire logic [PTR_W-1:0] ptr,
  output logic      [NREQ-1:0]  win,
  output logic                  any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [NREQ-1:0]   w_first;
  logic [2*NREQ-1:0] w_back;

  // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
  assign w_dbl   = {req, req} >> ptr;
  assign w_rot   = w_dbl[NREQ-1:0];
  assign w_first = w_rot & ((~w_rot) + {{(NREQ-1){1'b0}}, 1'b1});
  assign w_back  = {w_first, w_first} << ptr;
  assign win     = w_back[2*NREQ-1:NREQ];
  assign any     = |req;

endmodule
`default_nettype wire

// File: rtl/uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uio_bus_arbiter
// Purpose : Round-robin owner of the 8-bit uio pin bank with hold cap and
//           an undriven turnaround gap between owners.
// Revision: 1.0 - initial release
// ============================================================================
module uio_bus_arbiter
  import uio_bus_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int HOLD_MAX = 8,
  parameter int TURN     = 1
) (
  input wire logic          clk,
  input wire logic          rst_n,
  uio_bus_arbiter_if.slave  bus
);

  localparam int c_ptr_w  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int c_hold_w = $clog2(HOLD_MAX + 1);

  localparam logic [1:0]          c_st_idle   = S_IDLE;
  localparam logic [1:0]          c_st_own    = S_OWN;
  localparam logic [1:0]          c_st_turn   = S_TURN;
  localparam logic [c_ptr_w-1:0]  c_ptr_last  = c_ptr_w'(NREQ - 1);
  localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(HOLD_MAX);
  localparam logic [c_hold_w-1:0] c_hold_one  = c_hold_w'(1);
  localparam logic [2:0]          c_turn_last = 3'((TURN > 0) ? TURN - 1 : 0);

  logic [1:0]          r_state,  w_state_nx;
  logic [NREQ-1:0]     r_gnt,    w_gnt_nx;
  logic [c_ptr_w-1:0]  r_own,    w_own_nx;
  logic [c_ptr_w-1:0]  r_ptr,    w_ptr_nx;
  logic [c_hold_w-1:0] r_hold,   w_hold_nx;
  logic [2:0]          r_turn,   w_turn_nx;
  logic [UIO_W-1:0]    r_oe,     w_oe_nx;
  logic [UIO_W-1:0]    r_out,    w_out_nx;
  logic [UIO_W-1:0]    r_rdata,  w_rdata_nx;
  logic                r_rvalid, w_rvalid_nx;
  logic                r_busy;

  logic [NREQ-1:0]     w_win;
  logic                w_any;
  logic [c_ptr_w-1:0]  w_win_idx;
  logic                w_release;

  uio_bus_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (c_ptr_w)
  ) u_rr_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .win (w_win),
    .any (w_any)
  );

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_win[i]) w_win_idx = c_ptr_w'(i);
    end
  end

  assign w_release = bus.done[r_own] | ~bus.req[r_own] | ~bus.ena |
                     (r_hold == c_hold_last);

  always_comb begin
    w_state_nx  = r_state;
    w_gnt_nx    = r_gnt;
    w_own_nx    = r_own;
    w_ptr_nx    = r_ptr;
    w_hold_nx   = r_hold;
    w_turn_nx   = r_turn;
    w_oe_nx     = r_oe;
    w_out_nx    = r_out;
    w_rdata_nx  = r_rdata;
    w_rvalid_nx = 1'b0;
    case (r_state)
      c_st_idle: begin
        if (bus.ena && w_any) begin
          w_state_nx = c_st_own;
          w_gnt_nx   = w_win;
          w_own_nx   = w_win_idx;
          w_ptr_nx   = (w_win_idx == c_ptr_last) ? '0 : w_win_idx + c_ptr_one;
          w_hold_nx  = c_hold_one;
          w_oe_nx    = bus.wr[w_win_idx] ? OE_DRIVE : OE_FLOAT;
          w_out_nx   = bus.wdata[w_win_idx*UIO_W +: UIO_W];
        end
      end
      c_st_own: begin
        if (w_release) begin
          w_state_nx = (TURN > 0) ? c_st_turn : c_st_idle;
          w_gnt_nx   = '0;
          w_oe_nx    = OE_FLOAT;
          w_out_nx   = '0;
          w_turn_nx  = '0;
        end else begin
          w_hold_nx = r_hold + c_hold_one;
          w_oe_nx   = bus.wr[r_own] ? OE_DRIVE : OE_FLOAT;
          w_out_nx  = bus.wdata[r_own*UIO_W +: UIO_W];
          // Sample pins only when the bank was undriven during this cycle.
          if (r_oe == OE_FLOAT) begin
            w_rdata_nx  = bus.uio_in;
            w_rvalid_nx = 1'b1;
          end
        end
      end
      c_st_turn: begin
        if (r_turn == c_turn_last) begin
          w_state_nx = c_st_idle;
        end else begin
          w_turn_nx = r_turn + 3'd1;
        end
      end
      default: begin
        w_state_nx = c_st_idle;
        w_gnt_nx   = '0;
        w_oe_nx    = OE_FLOAT;
        w_out_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= c_st_idle;
      r_gnt    <= '0;
      r_own    <= '0;
      r_ptr    <= '0;
      r_hold   <= '0;
      r_turn   <= '0;
      r_oe     <= OE_FLOAT;
      r_out    <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_gnt    <= w_gnt_nx;
      r_own    <= w_own_nx;
      r_ptr    <= w_ptr_nx;
      r_hold   <= w_hold_nx;
      r_turn   <= w_turn_nx;
      r_oe     <= w_oe_nx;
      r_out    <= w_out_nx;
      r_rdata  <= w_rdata_nx;
      r_rvalid <= w_rvalid_nx;
      r_busy   <= (w_state_nx != c_st_idle);
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.busy    = r_busy;
  assign bus.rdata   = r_rdata;
  assign bus.rvalid  = r_rvalid;
  assign bus.uio_out = r_out;
  assign bus.uio_oe  = r_oe;

endmodule
`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uio_bus_arbiter
// Purpose : Scenario tasks plus a randomized run against a cycle-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uio_bus_arbiter;

  localparam int NREQ     = 4;
  localparam int HOLD_MAX = 8;
  localparam int TURN     = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uio_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  uio_bus_arbiter #(
    .NREQ     (NREQ),
    .HOLD_MAX (HOLD_MAX),
    .TURN     (TURN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the bus, for how long, how many quiet cycles remain.
  int              m_owner, m_len, m_quiet, m_ptr;
  logic [NREQ-1:0] e_gnt;
  logic [7:0]      e_oe, e_out, e_rdata;
  logic            e_rvalid, e_busy;

  task automatic model_edge();
    if (!rst_n) begin
      m_owner = -1; m_len = 0; m_quiet = 0; m_ptr = 0;
      e_gnt = '0; e_oe = 8'h00; e_out = 8'h00; e_rdata = 8'h00;
      e_rvalid = 1'b0; e_busy = 1'b0;
      return;
    end
    e_rvalid = 1'b0;
    if (m_owner >= 0) begin
      if (bus.done[m_owner] || !bus.req[m_owner] || !bus.ena || m_len == HOLD_MAX) begin
        m_owner = -1; m_quiet = TURN;
        e_gnt = '0; e_oe = 8'h00; e_out = 8'h00; e_busy = (TURN > 0);
      end else begin
        if (e_oe == 8'h00) begin
          e_rvalid = 1'b1;
          e_rdata  = bus.uio_in;
        end
        m_len++;
        e_oe  = bus.wr[m_owner] ? 8'hFF : 8'h00;
        e_out = bus.wdata[8*m_owner +: 8];
      end
    end else if (m_quiet > 0) begin
      m_quiet--;
      e_busy = (m_quiet > 0);
    end else if (bus.ena && bus.req != '0) begin
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (bus.req[c]) begin
          m_owner = c;
          break;
        end
      end
      m_len  = 1;
      m_ptr  = (m_owner + 1) % NREQ;
      e_gnt  = '0;
      e_gnt[m_owner] = 1'b1;
      e_oe   = bus.wr[m_owner] ? 8'hFF : 8'h00;
      e_out  = bus.wdata[8*m_owner +: 8];
      e_busy = 1'b1;
    end else begin
      e_busy = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.ena = 1'b1; bus.req = '0; bus.wr = '0; bus.wdata = '0;
    bus.done = '0; bus.uio_in = 8'h00;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] oh);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic test_reset();
    idle_inputs();
    bus.req = 4'b1111; bus.wr = 4'b1111; bus.wdata = 32'hDEAD_BEEF;
    rst_n = 1'b0;
    tick(); tick();
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b want 0000", bus.gnt); else n_pass++;
    n_checks++; if (bus.uio_oe !== 8'h00) $display("FAIL reset_oe: got %h want 00", bus.uio_oe); else n_pass++;
    n_checks++; if (bus.uio_out !== 8'h00) $display("FAIL reset_out: got %h want 00", bus.uio_out); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.rvalid !== 1'b0) $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); else n_pass++;
    n_checks++; if (bus.rdata !== 8'h00) $display("FAIL reset_rdata: got %h want 00", bus.rdata); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    logic [3:0] eg;
    logic [7:0] eo;
    do_reset();
    bus.req = 4'b0001; bus.wr = 4'b0001; bus.wdata = 32'h0000_00A5;
    for (int k = 1; k <= 6; k++) begin
      if (k == 4) bus.done = 4'b0001;
      if (k == 5) bus.done = 4'b0000;
      tick();
      eg = (k <= 3 || k == 6) ? 4'b0001 : 4'b0000;
      eo = (k <= 3 || k == 6) ? 8'hFF : 8'h00;
      n_checks++; if (bus.gnt !== eg) $display("FAIL wr_gnt cyc%0d: got %b want %b", k, bus.gnt, eg); else n_pass++;
      n_checks++; if (bus.uio_oe !== eo) $display("FAIL wr_oe cyc%0d: got %h want %h", k, bus.uio_oe, eo); else n_pass++;
      if (k <= 3) begin
        n_checks++; if (bus.uio_out !== 8'hA5) $display("FAIL wr_out cyc%0d: got %h want a5", k, bus.uio_out); else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int lens[$];
    int gaps[$];
    int run, gap, oe_bad;
    logic [3:0] prev;
    run = 0; gap = 0; oe_bad = 0; prev = '0;
    do_reset();
    bus.req = 4'b1111; bus.wr = 4'b1111; bus.wdata = $urandom;
    for (int t = 0; t < 80 && order.size() < 5; t++) begin
      tick();
      if (bus.gnt != '0) begin
        if (prev == '0) begin
          order.push_back(oh_idx(bus.gnt));
          if (order.size() > 1) gaps.push_back(gap);
          run = 0;
        end
        run++;
      end else begin
        if (prev != '0) begin
          lens.push_back(run);
          gap = 0;
        end
        gap++;
        if (bus.uio_oe != 8'h00) oe_bad++;
      end
      prev = bus.gnt;
    end
    n_checks++; if (order.size() != 5) $display("FAIL rr_grants: got %0d want 5", order.size()); else n_pass++;
    for (int i = 0; i < order.size(); i++) begin
      n_checks++; if (order[i] != i % NREQ) $display("FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % NREQ); else n_pass++;
    end
    for (int i = 0; i < lens.size(); i++) begin
      n_checks++; if (lens[i] != HOLD_MAX) $display("FAIL rr_len[%0d]: got %0d want %0d", i, lens[i], HOLD_MAX); else n_pass++;
    end
    for (int i = 0; i < gaps.size(); i++) begin
      n_checks++; if (gaps[i] != TURN + 1) $display("FAIL rr_gap[%0d]: got %0d want %0d", i, gaps[i], TURN + 1); else n_pass++;
    end
    n_checks++; if (oe_bad != 0) $display("FAIL rr_oe_in_gap: got %0d driven gap cycles want 0", oe_bad); else n_pass++;
  endtask

  task automatic test_read();
    logic [7:0] v;
    do_reset();
    bus.req = 4'b0100; bus.wr = 4'b0000; bus.uio_in = 8'h3C;
    tick();
    n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL rd_gnt: got %b want 0100", bus.gnt); else n_pass++;
    n_checks++; if (bus.rvalid !== 1'b0) $display("FAIL rd_first_rvalid: got %b want 0", bus.rvalid); else n_pass++;
    for (int k = 2; k <= HOLD_MAX; k++) begin
      v = (k == 2) ? 8'h3C : 8'($urandom);
      bus.uio_in = v;
      tick();
      n_checks++; if (bus.rvalid !== 1'b1) $display("FAIL rd_rvalid cyc%0d: got %b want 1", k, bus.rvalid); else n_pass++;
      n_checks++; if (bus.rdata !== v) $display("FAIL rd_rdata cyc%0d: got %h want %h", k, bus.rdata, v); else n_pass++;
    end
    for (int k = HOLD_MAX + 1; k <= HOLD_MAX + 2 + TURN; k++) begin
      tick();
      n_checks++; if (bus.rvalid !== 1'b0) $display("FAIL rd_rvalid_off cyc%0d: got %b want 0", k, bus.rvalid); else n_pass++;
    end
    n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL rd_regrant: got %b want 0100", bus.gnt); else n_pass++;
  endtask

  task automatic test_ena_drop();
    do_reset();
    bus.req = 4'b0010; bus.wr = 4'b0010; bus.wdata = 32'h0000_5A00;
    for (int k = 0; k < 4; k++) tick();
    n_checks++; if (bus.uio_oe !== 8'hFF) $display("FAIL ena_oe_before: got %h want ff", bus.uio_oe); else n_pass++;
    bus.ena = 1'b0;
    tick();
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL ena_gnt_drop: got %b want 0000", bus.gnt); else n_pass++;
    n_checks++; if (bus.uio_oe !== 8'h00) $display("FAIL ena_oe_drop: got %h want 00", bus.uio_oe); else n_pass++;
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL ena_blocked cyc%0d: got %b want 0000", k, bus.gnt); else n_pass++;
    end
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL ena_busy: got %b want 0", bus.busy); else n_pass++;
    bus.ena = 1'b1;
    tick();
    n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL ena_next_owner: got %b want 0100", bus.gnt); else n_pass++;
  endtask

  task automatic test_reset_mid_own();
    do_reset();
    bus.req = 4'b0100; bus.wr = 4'b0100; bus.wdata = $urandom;
    tick(); tick();
    n_checks++; if (bus.uio_oe !== 8'hFF) $display("FAIL rstmid_oe_before: got %h want ff", bus.uio_oe); else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL rstmid_gnt: got %b want 0000", bus.gnt); else n_pass++;
    n_checks++; if (bus.uio_oe !== 8'h00) $display("FAIL rstmid_oe: got %h want 00", bus.uio_oe); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", bus.busy); else n_pass++;
    bus.req = 4'b1111;
    tick();
    n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL rstmid_first: got %b want 0001", bus.gnt); else n_pass++;
  endtask

  task automatic test_done_nonowner();
    do_reset();
    bus.req = 4'b0101; bus.wr = 4'b0101; bus.wdata = $urandom;
    tick();
    n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL dn_first: got %b want 0001", bus.gnt); else n_pass++;
    bus.done = 4'b1000;
    tick();
    bus.done = 4'b0000;
    n_checks++; if (bus.gnt !== 4'b0001) $display("FAIL dn_ignored: got %b want 0001", bus.gnt); else n_pass++;
    tick();
    bus.done = 4'b0001;
    tick();
    bus.done = 4'b0000;
    n_checks++; if (bus.gnt !== 4'b0000) $display("FAIL dn_release: got %b want 0000", bus.gnt); else n_pass++;
    for (int k = 0; k <= TURN; k++) tick();
    n_checks++; if (bus.gnt !== 4'b0100) $display("FAIL dn_next: got %b want 0100", bus.gnt); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 1500; t++) begin
      rst_n     = ($urandom_range(0, 199) != 0);
      bus.ena   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      bus.wr    = 4'($urandom);
      bus.wdata = $urandom;
      bus.done  = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
      bus.uio_in = 8'($urandom);
      tick();
      n_checks++; if (bus.gnt !== e_gnt) $display("FAIL rnd_gnt t%0d: got %b want %b", t, bus.gnt, e_gnt); else n_pass++;
      n_checks++; if (bus.uio_oe !== e_oe) $display("FAIL rnd_oe t%0d: got %h want %h", t, bus.uio_oe, e_oe); else n_pass++;
      n_checks++; if (bus.uio_out !== e_out) $display("FAIL rnd_out t%0d: got %h want %h", t, bus.uio_out, e_out); else n_pass++;
      n_checks++; if (bus.busy !== e_busy) $display("FAIL rnd_busy t%0d: got %b want %b", t, bus.busy, e_busy); else n_pass++;
      n_checks++; if (bus.rvalid !== e_rvalid) $display("FAIL rnd_rvalid t%0d: got %b want %b", t, bus.rvalid, e_rvalid); else n_pass++;
      if (e_rvalid) begin
        n_checks++; if (bus.rdata !== e_rdata) $display("FAIL rnd_rdata t%0d: got %h want %h", t, bus.rdata, e_rdata); else n_pass++;
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_read();
    test_ena_drop();
    test_reset_mid_own();
    test_done_nonowner();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
